// File: rtl/fp_dot_accum_ctrl_if.sv
// Operand / MAC / result bundle of the dot-product accumulate controller.
// slave = controller side, master = feeder, MAC and result-sink side.
interface fp_dot_accum_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       cfg_rnd;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_last;
    logic [31:0]      mac_a;
    logic [31:0]      mac_b;
    logic [31:0]      mac_c;
    logic [2:0]       mac_rnd;
    logic [31:0]      mac_z;
    logic [7:0]       mac_status;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic [8:0]       out_flags;

    modport slave (
        input  cfg_rnd, in_valid, in_a, in_b, in_last, mac_z, mac_status, out_ready,
        output in_ready, mac_a, mac_b, mac_c, mac_rnd, out_valid, out_sum, out_count, out_flags
    );

    modport master (
        output cfg_rnd, in_valid, in_a, in_b, in_last, mac_z, mac_status, out_ready,
        input  in_ready, mac_a, mac_b, mac_c, mac_rnd, out_valid, out_sum, out_count, out_flags
    );
endinterface

// File: rtl/fp_dot_accum_ctrl.sv
// Feeds (a,b,acc) to an external FP MAC and folds z back into acc; one pair per MAC_LATENCY+2 cycles.
// in_ready only in IDLE; the finished sum is held in DONE until out_ready.
module fp_dot_accum_ctrl #(
    parameter int MAC_LATENCY = 0,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    fp_dot_accum_ctrl_if.slave bus
);
    localparam int LAT_W = (MAC_LATENCY > 0) ? $clog2(MAC_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      acc;
    logic [31:0]      mac_a_r;
    logic [31:0]      mac_b_r;
    logic [31:0]      mac_c_r;
    logic [CNT_W-1:0] count;
    logic [8:0]       flags;
    logic             last_r;
    logic [LAT_W-1:0] wcnt;
    logic             in_rdy;
    logic             out_vld;
    logic             accept;
    logic             z_take;
    logic             out_hs;

    assign accept = bus.in_valid && in_rdy;
    assign z_take = (state == S_WAIT) && (wcnt == '0);
    assign out_hs = (state == S_DONE) && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_WAIT;
            S_WAIT:  if (z_take) state_nxt = last_r ? S_DONE : S_IDLE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // in_ready is gated by rst so the feeder never sees a ready during reset.
    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state)
            S_IDLE:  in_rdy  = !rst;
            S_DONE:  out_vld = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mac_a_r <= '0;
            mac_b_r <= '0;
            mac_c_r <= '0;
            count   <= '0;
            flags   <= '0;
            last_r  <= 1'b0;
            wcnt    <= '0;
        end else begin
            if (accept) begin
                mac_a_r <= bus.in_a;
                mac_b_r <= bus.in_b;
                mac_c_r <= acc;
                last_r  <= bus.in_last;
                wcnt    <= LAT_W'(MAC_LATENCY);
                if (count == '1) begin
                    flags[8] <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if ((state == S_WAIT) && (wcnt != '0)) begin
                wcnt <= wcnt - LAT_W'(1);
            end
            // acc is opaque bits: NaN/Inf/denormal results go straight through.
            if (z_take) begin
                acc        <= bus.mac_z;
                flags[7:0] <= flags[7:0] | bus.mac_status;
            end
            if (out_hs) begin
                acc   <= '0;
                count <= '0;
                flags <= '0;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.mac_a     = mac_a_r;
    assign bus.mac_b     = mac_b_r;
    assign bus.mac_c     = mac_c_r;
    assign bus.mac_rnd   = bus.cfg_rnd;
    assign bus.out_sum   = acc;
    assign bus.out_count = count;
    assign bus.out_flags = flags;
endmodule
